chip_pump_sequencer: RTL

Sequences the pneumatic control layer of the ChIP chip for one fluid transfer at a time.
- Accepts a transfer command: inlet index, pump-cycle count and direction.
- Opens the selected prep-inlet valve, runs the 3-valve peristaltic pump for N full cycles, then re-closes.
- Drives the ctrl_inlet[4:0] and pump[2:0] pad nets of the chip top level.
- Replaces manual/host bit-banging of those valves.

---
 rtl/chip_ctrl_pkg.sv | 28 ++
 rtl/chip_pump_sequencer_if.sv | 27 ++
 rtl/chip_dwell_timer.sv | 29 ++
 rtl/chip_pump_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/chip_ctrl_pkg.sv
// Shared types and constants for the ChIP pneumatic control sequencer.
// The FLUSH state exists in the enum but is only reachable with CHIP_PUMP_FLUSH_EN.
package chip_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, OPEN, PUMP, CLOSE, FLUSH} state_t;

  localparam int NUM_INLETS = 5;
  localparam int PUMP_STEPS = 6;
  localparam logic VALVE_CLOSED = 1'b1;

  // Forward peristaltic order; reverse walks the same table backwards.
  localparam logic [2:0] PUMP_PATTERN [PUMP_STEPS] =
    '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  localparam logic [NUM_INLETS-1:0] INLETS_CLOSED = {NUM_INLETS{VALVE_CLOSED}};
  localparam logic [2:0]            PUMP_CLOSED   = {3{VALVE_CLOSED}};

  function automatic logic [NUM_INLETS-1:0] inlet_onehot(input logic [2:0] idx);
    return NUM_INLETS'(1) << idx;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chip_pump_sequencer_if.sv
// Command and valve-pad bundle between a host (master) and the pump sequencer (slave).
interface chip_pump_sequencer_if #(parameter int CNT_W = 8);
  import chip_ctrl_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_inlet;
  logic [CNT_W-1:0]      cmd_cycles;
  logic                  cmd_dir;
  logic                  abort;
  logic [NUM_INLETS-1:0] ctrl_inlet;
  logic [2:0]            pump;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [NUM_INLETS-1:0] flush_inlet;

  modport master (
    output cmd_valid, cmd_inlet, cmd_cycles, cmd_dir, abort,
    input  cmd_ready, ctrl_inlet, pump, busy, done, err, flush_inlet
  );

  modport slave (
    input  cmd_valid, cmd_inlet, cmd_cycles, cmd_dir, abort,
    output cmd_ready, ctrl_inlet, pump, busy, done, err, flush_inlet
  );
endinterface

// File: rtl/chip_dwell_timer.sv
// Loadable down-counter with a zero flag; one instance times every hold/settle/flush wait.
module chip_dwell_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/chip_pump_sequencer.sv
// Opens one prep inlet, runs the 3-valve peristaltic pump N cycles, then re-closes.
// Optional post-transfer flush of the used inlet is enabled by CHIP_PUMP_FLUSH_EN.
module chip_pump_sequencer
  import chip_ctrl_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int FLUSH_CYCLES  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chip_pump_sequencer_if.slave bus
);

  localparam int TW = $clog2(max3(HOLD_CYCLES, SETTLE_CYCLES, FLUSH_CYCLES) + 1);

  state_t                state_q, state_d;
  logic [NUM_INLETS-1:0] ctrl_inlet_q, ctrl_inlet_d;
  logic [2:0]            pump_q, pump_d;
  logic [2:0]            step_q, step_d, nstep;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  dir_q, dir_d;
  logic                  aborted_q, aborted_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wrap;
  logic                  cmd_ready;
  logic                  tmr_load, tmr_zero;
  logic [TW-1:0]         tmr_val;
`ifdef CHIP_PUMP_FLUSH_EN
  logic [2:0]            idx_q, idx_d;
  logic [NUM_INLETS-1:0] flush_q, flush_d;
`endif

  assign cmd_ready = (state_q == IDLE) && !bus.abort;

  chip_dwell_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    ctrl_inlet_d = ctrl_inlet_q;
    pump_d       = pump_q;
    step_d       = step_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;
    aborted_d    = aborted_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
`ifdef CHIP_PUMP_FLUSH_EN
    idx_d        = idx_q;
    flush_d      = flush_q;
`endif
    if (dir_q) begin
      wrap  = (step_q == 3'd0);
      nstep = wrap ? 3'(PUMP_STEPS-1) : step_q - 3'd1;
    end else begin
      wrap  = (step_q == 3'(PUMP_STEPS-1));
      nstep = wrap ? 3'd0 : step_q + 3'd1;
    end

    case (state_q)
      IDLE: if (bus.cmd_valid && cmd_ready) begin
        if (bus.cmd_inlet >= 3'(NUM_INLETS)) begin
          err_d = 1'b1;
        end else if (bus.cmd_cycles == '0) begin
          done_d = 1'b1;
        end else begin
          state_d      = OPEN;
          ctrl_inlet_d = ~inlet_onehot(bus.cmd_inlet);
          dir_d        = bus.cmd_dir;
          remaining_d  = bus.cmd_cycles;
          aborted_d    = 1'b0;
          tmr_load     = 1'b1;
          tmr_val      = TW'(SETTLE_CYCLES-1);
`ifdef CHIP_PUMP_FLUSH_EN
          idx_d        = bus.cmd_inlet;
`endif
        end
      end
      OPEN: if (tmr_zero) begin
        state_d  = PUMP;
        step_d   = dir_q ? 3'(PUMP_STEPS-1) : 3'd0;
        pump_d   = dir_q ? PUMP_PATTERN[PUMP_STEPS-1] : PUMP_PATTERN[0];
        tmr_load = 1'b1;
        tmr_val  = TW'(HOLD_CYCLES-1);
      end
      // Cycle count drops on each wrap; the final wrap leaves for CLOSE instead.
      PUMP: if (tmr_zero) begin
        tmr_load = 1'b1;
        if (wrap && remaining_q == CNT_W'(1)) begin
          state_d      = CLOSE;
          pump_d       = PUMP_CLOSED;
          ctrl_inlet_d = INLETS_CLOSED;
          tmr_val      = TW'(SETTLE_CYCLES-1);
        end else begin
          if (wrap) remaining_d = remaining_q - CNT_W'(1);
          step_d  = nstep;
          pump_d  = PUMP_PATTERN[nstep];
          tmr_val = TW'(HOLD_CYCLES-1);
        end
      end
      CLOSE: if (tmr_zero) begin
        if (aborted_q || bus.abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
`ifdef CHIP_PUMP_FLUSH_EN
          state_d  = FLUSH;
          flush_d  = inlet_onehot(idx_q);
          tmr_load = 1'b1;
          tmr_val  = TW'(FLUSH_CYCLES-1);
`else
          state_d  = IDLE;
          done_d   = 1'b1;
`endif
        end
      end
`ifdef CHIP_PUMP_FLUSH_EN
      FLUSH: if (tmr_zero) begin
        state_d = IDLE;
        flush_d = '0;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Abort in CLOSE only marks the outcome so a held abort cannot stall the settle.
    if (bus.abort && state_q != IDLE && state_q != CLOSE) begin
      state_d      = CLOSE;
      pump_d       = PUMP_CLOSED;
      ctrl_inlet_d = INLETS_CLOSED;
      aborted_d    = 1'b1;
      done_d       = 1'b0;
      err_d        = 1'b0;
      tmr_load     = 1'b1;
      tmr_val      = TW'(SETTLE_CYCLES-1);
`ifdef CHIP_PUMP_FLUSH_EN
      flush_d      = '0;
`endif
    end else if (bus.abort && state_q == CLOSE) begin
      aborted_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ctrl_inlet_q <= INLETS_CLOSED;
      pump_q       <= PUMP_CLOSED;
      step_q       <= '0;
      remaining_q  <= '0;
      dir_q        <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef CHIP_PUMP_FLUSH_EN
      idx_q        <= '0;
      flush_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ctrl_inlet_q <= ctrl_inlet_d;
      pump_q       <= pump_d;
      step_q       <= step_d;
      remaining_q  <= remaining_d;
      dir_q        <= dir_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef CHIP_PUMP_FLUSH_EN
      idx_q        <= idx_d;
      flush_q      <= flush_d;
`endif
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.ctrl_inlet = ctrl_inlet_q;
  assign bus.pump       = pump_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
`ifdef CHIP_PUMP_FLUSH_EN
  assign bus.flush_inlet = flush_q;
`else
  assign bus.flush_inlet = '0;
`endif

endmodule
